// File: rtl/freq_detect_pkg.sv
// Shared types and constants for the frequency detector: FSM state encoding,
// match-counter width and the half-period ceiling helper.
package freq_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } fd_state_e;

  localparam int CODE_W_DEF = 3;
  // match counter must hold MATCH_CNT up to 7
  localparam int MATCH_W    = 3;

  // Longest legal half-period for a given code width.
  function automatic int hp_max(input int code_w);
    return 1 << code_w;
  endfunction

  localparam int HP_MAX = hp_max(CODE_W_DEF);

endpackage

// File: rtl/edge_sync.sv
// Input conditioning for sigIn: optional 2-flop synchronizer followed by a
// sample/previous-sample pair whose XOR is a one-cycle edge pulse.
// FREQ_DETECT_SYNC_EN defined: synchronizer inserted (one extra cycle of lag).
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_pulse
);

  logic samp_q, samp_d;
  logic prev_q, prev_d;

`ifdef FREQ_DETECT_SYNC_EN
  logic meta_q, meta_d;

  // two-flop synchronizer ahead of the sample pair
  always_comb begin
    meta_d = sig_in;
    samp_d = meta_q;
    prev_d = samp_q;
  end

  // register the synchronizer and sample pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      samp_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      samp_q <= samp_d;
      prev_q <= prev_d;
    end
  end
`else
  // input already synchronous: sample directly
  always_comb begin
    samp_d = sig_in;
    prev_d = samp_q;
  end

  // register the sample pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      samp_q <= samp_d;
      prev_q <= prev_d;
    end
  end
`endif

  // both polarities of transition count as an edge
  assign edge_pulse = samp_q ^ prev_q;

endmodule

// File: rtl/frequency_detector.sv
// Recovers the selector code of a divided clock by timing its half-period.
// Locks after MATCH_CNT identical consecutive measurements, flags a fault when
// no edge arrives within 2^CODE_W cycles. FREQ_DETECT_SYNC_EN (in edge_sync)
// adds an input synchronizer.
module frequency_detector
  import freq_detect_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DEF,
  parameter int MATCH_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sigIn,
  output logic [CODE_W-1:0] code,
  output logic              locked,
  output logic              codeStb,
  output logic              fault
);

  localparam logic [CODE_W:0]    HP_MAX_V  = (CODE_W+1)'(hp_max(CODE_W));
  localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(MATCH_CNT);
  localparam logic [MATCH_W-1:0] MATCH_SAT = '1;

  logic edge_pulse;

  edge_sync u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sigIn),
    .edge_pulse (edge_pulse)
  );

  fd_state_e          state_q, state_d;
  logic [CODE_W:0]    cnt_q, cnt_d;
  logic [CODE_W:0]    prev_hp_q, prev_hp_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               locked_q, locked_d;
  logic               stb_q, stb_d;
  logic               fault_q, fault_d;

  logic [CODE_W:0]    hp;
  logic [CODE_W-1:0]  code_cand;
  logic [MATCH_W-1:0] match_nxt;
  logic               sat_now;

  // half-period counter, candidate code and next-state/output logic
  always_comb begin
    state_d   = state_q;
    prev_hp_d = prev_hp_q;
    match_d   = match_q;
    code_d    = code_q;
    locked_d  = locked_q;
    stb_d     = 1'b0;
    fault_d   = fault_q;

    if (edge_pulse)              cnt_d = '0;
    else if (cnt_q != HP_MAX_V)  cnt_d = cnt_q + (CODE_W+1)'(1);
    else                         cnt_d = cnt_q;

    hp        = cnt_q + (CODE_W+1)'(1);
    code_cand = CODE_W'(HP_MAX_V - hp);
    // saturate so a long lock cannot wrap the counter back to a lock value
    match_nxt = (hp != prev_hp_q)    ? MATCH_W'(1) :
                (match_q == MATCH_SAT) ? match_q : match_q + MATCH_W'(1);
    // edge takes priority: a saturation-cycle edge is a legal hp of 2^CODE_W
    sat_now   = !edge_pulse && (cnt_d == HP_MAX_V);

    case (state_q)
      ST_IDLE: begin
        // first edge only starts timing
        if (edge_pulse) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (edge_pulse) begin
          prev_hp_d = hp;
          match_d   = match_nxt;
          if (match_nxt == MATCH_TGT) begin
            state_d  = ST_LOCKED;
            code_d   = code_cand;
            locked_d = 1'b1;
            stb_d    = 1'b1;
          end
        end else if (sat_now) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (edge_pulse) begin
          prev_hp_d = hp;
          match_d   = match_nxt;
          if (hp != prev_hp_q) begin
            state_d  = ST_MEASURE;
            locked_d = 1'b0;
          end
        end else if (sat_now) begin
          state_d  = ST_FAULT;
          locked_d = 1'b0;
          fault_d  = 1'b1;
        end
      end
      ST_FAULT: begin
        // counter is saturated, so this edge carries no valid hp
        if (edge_pulse) begin
          state_d   = ST_MEASURE;
          fault_d   = 1'b0;
          match_d   = '0;
          prev_hp_d = '0;
        end
      end
    endcase
  end

  // state machine, measurement state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      prev_hp_q <= '0;
      match_q   <= '0;
      code_q    <= '0;
      locked_q  <= 1'b0;
      stb_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_hp_q <= prev_hp_d;
      match_q   <= match_d;
      code_q    <= code_d;
      locked_q  <= locked_d;
      stb_q     <= stb_d;
      fault_q   <= fault_d;
    end
  end

  assign code    = code_q;
  assign locked  = locked_q;
  assign codeStb = stb_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_frequency_detector.sv
// Scoreboard bench for frequency_detector: each sigIn toggle pushes the output
// values expected on the cycle that edge becomes visible; a monitor pops and
// compares them as the cycles arrive.
module tb_frequency_detector;

`ifdef FREQ_DETECT_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_in;
  logic [2:0] code;
  logic       locked, code_stb, fault;
  logic [5:0] obs;

  frequency_detector #(.CODE_W(3), .MATCH_CNT(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .sigIn   (sig_in),
    .code    (code),
    .locked  (locked),
    .codeStb (code_stb),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  assign obs = {code, locked, code_stb, fault};

  typedef struct {
    int         at;
    string      tag;
    logic [5:0] v;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;
  int  cyc      = 0;
  int  n_chk    = 0;
  int  n_fail   = 0;
  int  stb_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push(input string tag, input int at, input logic [2:0] c,
                      input logic l, input logic s, input logic f);
    sb_t e;
    e.at  = at;
    e.tag = tag;
    e.v   = {c, l, s, f};
    sb_q.push_back(e);
  endtask

  // toggle sigIn; returns the cycle on which the resulting outputs appear
  task automatic tog(output int u);
    sig_in = ~sig_in;
    u = cyc + 1 + LAG;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: count strobes and retire scoreboard entries due this cycle
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst && code_stb) stb_seen++;
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.at == cyc) chk(mon_e.tag, 32'(obs), 32'(mon_e.v));
      else                 chk({mon_e.tag, "_missed"}, cyc, mon_e.at);
    end
  end

  initial begin
    int u;
    rst    = 1'b0;
    sig_in = 1'b0;
    wait_n(3);
    chk("reset_vals", 32'(obs), 0);
    rst = 1'b1;
    wait_n(20);
    chk("idle_static", 32'(obs), 0);

    // code 7: toggle every cycle
    for (int k = 1; k <= 8; k++) begin
      wait_n(1); tog(u);
      if (k == 2) push("A_meas",   u, 3'd0, 0, 0, 0);
      if (k == 3) push("A_lock",   u, 3'd7, 1, 1, 0);
      if (k == 4) push("A_stb1",   u, 3'd7, 1, 0, 0);
      if (k == 8) push("A_hold",   u, 3'd7, 1, 0, 0);
    end
    // code 2: every 6 cycles
    for (int k = 1; k <= 3; k++) begin
      wait_n(6); tog(u);
      if (k == 1) push("B_unlock", u, 3'd7, 0, 0, 0);
      if (k == 2) push("B_lock",   u, 3'd2, 1, 1, 0);
      if (k == 3) push("B_hold",   u, 3'd2, 1, 0, 0);
    end
    // code 0: every 8 cycles (edge on the saturation cycle)
    for (int k = 1; k <= 3; k++) begin
      wait_n(8); tog(u);
      if (k == 1) push("C_unlock", u, 3'd2, 0, 0, 0);
      if (k == 2) push("C_lock",   u, 3'd0, 1, 1, 0);
      if (k == 3) push("C_hold",   u, 3'd0, 1, 0, 0);
    end
    // code 5: every 3 cycles, then go static
    for (int k = 1; k <= 3; k++) begin
      wait_n(3); tog(u);
      if (k == 1) push("D_unlock", u, 3'd0, 0, 0, 0);
      if (k == 2) push("D_lock",   u, 3'd5, 1, 1, 0);
      if (k == 3) push("D_hold",   u, 3'd5, 1, 0, 0);
    end
    push("D_prefault", u + 7, 3'd5, 1, 0, 0);
    push("D_fault",    u + 8, 3'd5, 0, 0, 1);
    wait_n(9);
    // resume every 3 cycles out of fault
    for (int k = 1; k <= 4; k++) begin
      wait_n(3); tog(u);
      if (k == 1) push("E_clear",  u, 3'd5, 0, 0, 0);
      if (k == 3) push("E_relock", u, 3'd5, 1, 1, 0);
      if (k == 4) push("E_hold",   u, 3'd5, 1, 0, 0);
    end
    push("E_fault", u + 8, 3'd5, 0, 0, 1);
    // every 12 cycles: fault each period, never locks
    for (int k = 1; k <= 3; k++) begin
      wait_n(12); tog(u);
      push($sformatf("F_clear%0d", k), u,     3'd5, 0, 0, 0);
      push($sformatf("F_fault%0d", k), u + 8, 3'd5, 0, 0, 1);
    end
    // period 4, reset part-way through measuring
    wait_n(12); tog(u);
    push("G_clear", u, 3'd5, 0, 0, 0);
    wait_n(4); tog(u);
    push("G_meas",  u, 3'd5, 0, 0, 0);
    wait_n(4);
    #2 rst = 1'b0; sig_in = 1'b0;
    #1 chk("reset_async", 32'(obs), 0);
    #8 rst = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      wait_n(4); tog(u);
      if (k == 1) push("H_start", u, 3'd0, 0, 0, 0);
      if (k == 2) push("H_meas",  u, 3'd0, 0, 0, 0);
      if (k == 3) push("H_lock",  u, 3'd4, 1, 1, 0);
      if (k == 4) push("H_hold",  u, 3'd4, 1, 0, 0);
    end

    for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    chk("stb_total", stb_seen, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frequency_detector.md
# frequency_detector

Decoder counterpart to the frequency selector: measures the half-period of an incoming divided clock (`sigIn`, same clock domain or asynchronous) and recovers the 3-bit selector code that would generate it. It sits on the receive side of the lab's clock-division chain and reports a locked code plus a one-cycle strobe, so a downstream unit can re-create or verify the selected frequency. Selector convention: code `c` produces a square wave toggling every `2^CODE_W - c` clk cycles.

## Interface
- `CODE_W`, 3: code width; legal half-periods are 1..2^CODE_W cycles.
- `MATCH_CNT`, 2: consecutive identical half-period measurements required to lock (range 1..7).

- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `sigIn` input 1: divided clock under measurement.
- `code` output CODE_W: recovered selector code, `2^CODE_W - halfPeriod`.
- `locked` output 1: code is valid and stable.
- `codeStb` output 1: one-cycle pulse on every entry to LOCKED.
- `fault` output 1: no edge seen for more than 2^CODE_W cycles.

## Operation
- Edge detect: `edge` = XOR of two consecutive registered samples of `sigIn`; both rising and falling edges count.
- Counter `cnt` (CODE_W+1 bits): cleared on an edge cycle, otherwise increments, saturating at 2^CODE_W.
- On an edge, measured `hp = cnt + 1`. `code` candidate = `(2^CODE_W - hp)` truncated to CODE_W bits (hp=1 → 7, hp=8 → 0 for CODE_W=3).
- `match` counter: incremented when `hp` equals the previous `hp`, reset to 1 otherwise.
- States:
  - IDLE: after reset; the first edge → MEASURE; no `hp` is computed for this edge.
  - MEASURE: compute `hp` on each edge; `match == MATCH_CNT` → LOCKED, load `code`, pulse `codeStb`.
  - LOCKED: an edge with a differing `hp` → MEASURE, `match` = 1, `locked` cleared, `code` holds its last value.
  - FAULT: entered from MEASURE/LOCKED when `cnt` saturates with no edge. Clears `locked` and sets `fault`. The next edge → MEASURE, clears `fault`, restarts `match`.
- IDLE never faults; a static `sigIn` after reset leaves all outputs at their reset value.

## Timing
- Reset values: `code` = 0, `locked` = 0, `codeStb` = 0, `fault` = 0, state IDLE, `cnt` = 0, `match` = 0, sample registers = 0.
- All outputs registered; they update on the clk edge following the edge-detect cycle.
- Lock latency from the first detected edge is MATCH_CNT+... no: it is `(MATCH_CNT + 1)` edges. The first edge only starts timing; MATCH_CNT equal measurements follow; `locked`/`codeStb` rise 1 cycle after the last edge is detected.
- Fault asserts on the cycle `cnt` reaches 2^CODE_W, i.e. 2^CODE_W cycles after the last detected edge.
- An edge and saturation on the same cycle: the edge wins, with `hp` = 2^CODE_W (legal).
- Reset asserted mid-measurement: immediate return to reset values; no `codeStb` is emitted.

## Configuration
- `FREQ_DETECT_SYNC_EN` defined: `sigIn` passes through a 2-flop synchronizer before edge detect. Edge detection lags `sigIn` by 3 clk edges.
- Not defined: `sigIn` must be synchronous to `clk`. A single sample register feeds edge detect, with 2 clk edges lag.
- Measured `hp` and `code` are identical in both builds; only absolute latency differs.

## Structure
- `freq_detect_pkg`: state encoding localparams (IDLE/MEASURE/LOCKED/FAULT) and the derived `HP_MAX = 2^CODE_W`.
- Sub-module `edge_sync`: the optional synchronizer plus edge detect. It is the only place `FREQ_DETECT_SYNC_EN` is tested, and outputs a one-cycle `edge` pulse.
- Top level holds the counter, match logic, state machine and output registers.

## Test plan
- `sigIn` toggling every cycle (selector code 7) → `locked` = 1, `code` = 7, a single `codeStb` pulse after 3 edges, `fault` = 0.
- `sigIn` toggling every 6 cycles (code 2) → `code` = 2, `locked` = 1. Then switch to toggling every 8 cycles → `locked` drops on the first 8-cycle edge, relocks with `code` = 0 and a second `codeStb`.
- Locked on code 5 (toggle every 3), then hold `sigIn` static → `fault` = 1 exactly 8 cycles after the last edge, `locked` = 0, `code` stays 5. Resume toggling every 3 → `fault` clears, relock with `code` = 5.
- Toggle every 12 cycles → `fault` pulses each period, `locked` never rises.
- Reset pulse (`rst` low 9 ns) mid-measurement at toggle period 4 → all outputs 0 immediately. Relock to `code` = 4 needs 3 fresh edges.
- Build with and without `FREQ_DETECT_SYNC_EN` using the same stimulus → identical `code` values; `locked` rise time differs by exactly 1 cycle.
